// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU function codes, funct/ALUOp encodings and EX-stage control bundle.
package mips_pkg;

    localparam logic [3:0] FC_ADD     = 4'b0010;
    localparam logic [3:0] FC_SUB     = 4'b0110;
    localparam logic [3:0] FC_AND     = 4'b0000;
    localparam logic [3:0] FC_OR      = 4'b0001;
    localparam logic [3:0] FC_NOR     = 4'b0011;
    localparam logic [3:0] FC_XOR     = 4'b0100;
    localparam logic [3:0] FC_MUL     = 4'b1010;
    localparam logic [3:0] FC_DIV     = 4'b1111;
    localparam logic [3:0] FC_ILLEGAL = 4'b1110;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_DIV  = 6'h1A;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       illegal;
        logic [3:0] funct_c;
        logic [4:0] dest;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '{funct_c: FC_ADD, default: '0};

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zero_ext);
        return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_control_decode.sv
// alu_control_decode: maps ALUOp and R-type funct to the 4-bit ALU function code.
module alu_control_decode
    import mips_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] funct_c,
    output logic       illegal
);

    always_comb begin
        funct_c = FC_ADD;
        illegal = 1'b0;
        case (alu_op)
            OP_ADD: funct_c = FC_ADD;
            OP_SUB: funct_c = FC_SUB;
            OP_AND: funct_c = FC_AND;
            OP_OR:  funct_c = FC_OR;
            OP_XOR: funct_c = FC_XOR;
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: funct_c = FC_ADD;
                    F_SUB, F_SUBU: funct_c = FC_SUB;
                    F_AND:         funct_c = FC_AND;
                    F_OR:          funct_c = FC_OR;
                    F_XOR:         funct_c = FC_XOR;
                    F_NOR:         funct_c = FC_NOR;
                    F_MULT:        funct_c = FC_MUL;
                    F_DIV:         funct_c = FC_DIV;
                    default: begin
                        funct_c = FC_ILLEGAL;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: funct_c = FC_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU, with operand select,
// EX/MEM and MEM/WB forwarding, and load-use hazard detection.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [15:0] id_imm,
    input  logic [5:0]  id_funct,
    input  logic [2:0]  id_alu_op,
    input  logic        id_alu_src,
    input  logic        id_zero_ext,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_reg_write,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_result,
    output logic [3:0]  FunctC,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [31:0] store_data,
    output logic [4:0]  ex_dest,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_illegal,
    output logic        load_use_stall
);

    ex_ctrl_t    ctrl_d, ctrl_q;
    logic [31:0] rs_val_d, rs_val_q, rt_val_d, rt_val_q, imm_d, imm_q;
    logic [4:0]  rs_d, rs_q, rt_d, rt_q;
    logic [3:0]  dec_funct_c;
    logic        dec_illegal;
    logic [31:0] fwd_rs, fwd_rt;

    alu_control_decode u_dec (
        .alu_op  (id_alu_op),
        .funct   (id_funct),
        .funct_c (dec_funct_c),
        .illegal (dec_illegal)
    );

    always_comb begin
        ctrl_d   = ctrl_q;
        rs_val_d = rs_val_q;
        rt_val_d = rt_val_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        if (flush) begin
            ctrl_d   = CTRL_BUBBLE;
            rs_val_d = '0;
            rt_val_d = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
        end else if (!stall) begin
            ctrl_d = '{
                reg_write:  id_reg_write,
                mem_read:   id_mem_read,
                mem_write:  id_mem_write,
                mem_to_reg: id_mem_to_reg,
                alu_src:    id_alu_src,
                illegal:    dec_illegal,
                funct_c:    dec_funct_c,
                dest:       id_reg_dst ? id_rd : id_rt
            };
            rs_val_d = id_rs_val;
            rt_val_d = id_rt_val;
            imm_d    = ext_imm(id_imm, id_zero_ext);
            rs_d     = id_rs;
            rt_d     = id_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= CTRL_BUBBLE;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
        end
    end

    // EX/MEM is the younger producer, so it takes priority; $zero never forwards
    assign fwd_rs = (exm_reg_write && rs_q != 5'd0 && exm_rd == rs_q) ? exm_result :
                    (mwb_reg_write && rs_q != 5'd0 && mwb_rd == rs_q) ? mwb_result : rs_val_q;
    assign fwd_rt = (exm_reg_write && rt_q != 5'd0 && exm_rd == rt_q) ? exm_result :
                    (mwb_reg_write && rt_q != 5'd0 && mwb_rd == rt_q) ? mwb_result : rt_val_q;

    assign A             = fwd_rs;
    assign B             = ctrl_q.alu_src ? imm_q : fwd_rt;
    assign store_data    = fwd_rt;
    assign FunctC        = ctrl_q.funct_c;
    assign ex_dest       = ctrl_q.dest;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_illegal    = ctrl_q.illegal;

    assign load_use_stall = ctrl_q.mem_read && ctrl_q.dest != 5'd0 &&
                            (ctrl_q.dest == id_rs || ctrl_q.dest == id_rt);

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select stage of the 32-bit MIPS datapath; sits directly upstream of the ALU select block and produces its `FunctC`, `A` and `B` inputs. Each cycle it captures decoded instruction fields from the ID stage, holds them for one cycle, then drives the ALU from the held state. Along the way it decodes the ALU function, selects register or immediate operands, applies EX/MEM and MEM/WB forwarding, and flags load-use hazards.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; one clock, sampled on rising edge
- `stall`  in  1  hold current contents; ignore ID inputs
- `flush`  in  1  load a bubble on the next edge
- `id_rs_val`, `id_rt_val`  in  32  register-file read data
- `id_rs`, `id_rt`, `id_rd`  in  5  register specifiers
- `id_imm`  in  16  instruction immediate
- `id_funct`  in  6  R-type funct field
- `id_alu_op`  in  3  000 add, 001 sub, 010 R-type, 011 and, 100 or, 101 xor, others add
- `id_alu_src`, `id_zero_ext`, `id_reg_dst`  in  1  B=immediate; zero-extend immediate; dest=rd
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1  control bits
- `exm_reg_write`, `exm_rd`, `exm_result`  in  1/5/32  EX/MEM forwarding source
- `mwb_reg_write`, `mwb_rd`, `mwb_result`  in  1/5/32  MEM/WB forwarding source
- `FunctC`  out  4  ALU function code
- `A`, `B`  out  32  ALU operands
- `store_data`  out  32  forwarded rt value for stores
- `ex_dest`  out  5  destination register
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  out  1  registered control bits
- `ex_illegal`  out  1  funct not recognised
- `load_use_stall`  out  1  hazard request to the ID/IF stages

## Operation
- Register update priority on each edge: reset > flush > stall > load.
- Reset and flush: all control outputs 0, `ex_dest`=0, data registers 0, stored FunctC=4'b0010. Result at outputs: `A`=`B`=0, `FunctC`=4'b0010.
- Load captures:
  - `id_rs_val`, `id_rt_val`, `id_rs`, `id_rt`
  - extended immediate: zero-extended if `id_zero_ext`, else sign-extended
  - dest = `id_reg_dst` ? `id_rd` : `id_rt`
  - decoded FunctC and all control bits
- FunctC decode is done before the register:
  - ALUOp 000 → 0010, 001 → 0110, 011 → 0000, 100 → 0001, 101 → 0100
  - R-type funct: 0x20/0x21 → 0010, 0x22/0x23 → 0110, 0x24 → 0000, 0x25 → 0001, 0x26 → 0100, 0x27 → 0011, 0x18 → 1010, 0x1A → 1111
  - Any other funct → 1110 with `ex_illegal`=1
- Forwarding is combinational from the held rs/rt and the forwarding inputs:
  - Forward from EX/MEM if `exm_reg_write` and `exm_rd`==reg and reg≠0; else from MEM/WB under the same test; else the held value.
  - EX/MEM wins when both match.
- `A` = forwarded rs. `store_data` = forwarded rt. `B` = `id_alu_src`-held ? extended immediate : forwarded rt.
- `load_use_stall` = `ex_mem_read` & `ex_dest`≠0 & (`ex_dest`==`id_rs` | `ex_dest`==`id_rt`). The hazard unit turns this into `stall` on IF/ID and `flush` on this stage; the block does not self-stall.

## Timing
- Latency is one cycle: ID inputs present before edge N appear at the outputs after edge N.
- Forwarding and `load_use_stall` are zero-latency combinational paths.
- Stall holds every register indefinitely. Forwarding still tracks changing `exm_`/`mwb_` inputs during a stall.
- Flush and stall in the same cycle: flush wins.
- Reset asserted mid-stall: bubble on the next edge.

## Structure
- Shared package `mips_pkg`:
  - FunctC constants: ADD, SUB, AND, OR, NOR, XOR, MUL, DIV, ILLEGAL
  - funct codes and ALUOp codes
- Sub-module `alu_control_decode`: combinational; (`alu_op`, `funct`) → (`FunctC`, `illegal`).
- Forwarding mux stays inline.
- Estimated 150–250 lines total.

## Test plan
- Reset, then idle: `ex_reg_write`=0, `FunctC`=0010, `A`=`B`=0.
- R-type sub: `id_rs_val`=10, `id_rt_val`=3, funct 0x22, ALUOp 010; after one edge → `FunctC`=0110, `A`=10, `B`=3. Repeat with funct 0x3F → `FunctC`=1110, `ex_illegal`=1.
- Immediates, both with `id_imm`=0xFFFF and alu_src=1:
  - `id_zero_ext`=0 → `B`=0xFFFFFFFF
  - `id_zero_ext`=1 with ALUOp 100 → `B`=0x0000FFFF, `FunctC`=0001
- Forwarding, with held rs=5:
  - `exm_rd`=5, `exm_result`=0xAA, `mwb_rd`=5, `mwb_result`=0xBB → `A`=0xAA
  - drop `exm_reg_write` → `A`=0xBB
  - rs=0 with both matching → `A`=held value
- Load-use: EX holds lw with dest 7, `id_rs`=7 → `load_use_stall`=1. Then assert `flush`+`stall` together → bubble loaded, `ex_mem_read`=0.
- Stall: hold `stall` 3 cycles while ID inputs change → all outputs unchanged. Release → the new instruction loads on the next edge.
